// File: rtl/typing_pkg.sv
// Shared types and constants for the typing-game session controller.
// Contents: FSM state encoding, datapath widths, the WPM scale factor and
// a saturation helper that narrows a divider quotient to the WPM width.
package typing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RUNNING   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam int WPM_SCALE  = 60000;  // 60 s/min * 10 tenths/s * 100 (two decimals)
  localparam int WORD_W     = 11;
  localparam int TIME_W     = 11;
  localparam int WPM_W      = 16;
  localparam int DIVIDEND_W = 27;
  localparam int DIV_CYCLES = 27;     // one quotient bit per clock

  // Clamp a full-width quotient to the WPM output width.
  function automatic logic [WPM_W-1:0] wpm_saturate(input logic [DIVIDEND_W-1:0] q);
    if (|q[DIVIDEND_W-1:WPM_W]) begin
      return {WPM_W{1'b1}};
    end else begin
      return q[WPM_W-1:0];
    end
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring sequential divider, 27-bit dividend by 11-bit divisor.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               load operands; the first quotient bit is resolved in
//                       the loading cycle, so done rises DIV_CYCLES clocks later
//   cancel              abandon any divide in flight (wins over start)
//   dividend, divisor   operands, sampled when start is high
//   busy                divide in progress
//   done                one-cycle pulse, quotient valid while high
//   quotient            result (divisor must be non-zero)
module seq_divider
  import typing_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cancel,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [TIME_W-1:0]     divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // Returns {remainder, shifted quotient}.
  function automatic logic [TIME_W+DIVIDEND_W-1:0] div_step(
    input logic [TIME_W-1:0]     rem,
    input logic [DIVIDEND_W-1:0] quo,
    input logic [TIME_W-1:0]     dvs
  );
    logic [TIME_W:0] trial;
    trial = {rem, quo[DIVIDEND_W-1]};
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      return {trial[TIME_W-1:0], quo[DIVIDEND_W-2:0], 1'b1};
    end else begin
      return {trial[TIME_W-1:0], quo[DIVIDEND_W-2:0], 1'b0};
    end
  endfunction

  logic [TIME_W-1:0]            rem_r;
  logic [TIME_W-1:0]            dvs_r;
  logic [DIVIDEND_W-1:0]        quo_r;
  logic [4:0]                   cnt_r;
  logic                         busy_r;
  logic                         done_r;
  logic [TIME_W+DIVIDEND_W-1:0] first_s;
  logic [TIME_W+DIVIDEND_W-1:0] next_s;

  // Step results for a fresh launch and for the iteration in flight.
  always_comb begin
    first_s = div_step(TIME_W'(0), dividend, divisor);
    next_s  = div_step(rem_r, quo_r, dvs_r);
  end

  // Divider sequencing: load, iterate, pulse done on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r  <= '0;
      dvs_r  <= '0;
      quo_r  <= '0;
      cnt_r  <= 5'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (cancel) begin
      cnt_r  <= 5'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      {rem_r, quo_r} <= first_s;
      dvs_r          <= divisor;
      cnt_r          <= 5'(DIV_CYCLES - 1);
      busy_r         <= 1'b1;
      done_r         <= 1'b0;
    end else if (busy_r) begin
      {rem_r, quo_r} <= next_s;
      cnt_r          <= cnt_r - 5'd1;
      if (cnt_r == 5'd1) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign quotient = quo_r;

endmodule

// File: rtl/typing_session_ctrl.sv
// Session sequencer for the typing game: IDLE -> COUNTDOWN -> RUNNING -> DONE.
// Drives the stopwatch controls, counts finished words, times the session
// with its own 0.1 s tick and reports live/final WPM (x100) via seq_divider.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start_btn       pulse: start a session from IDLE or DONE
//   word_complete   pulse per finished word
//   game_over_in    level: word list exhausted, ends the session
//   sw_reset        stopwatch clear (IDLE/COUNTDOWN)
//   sw_start        stopwatch run enable (RUNNING)
//   state           current state encoding
//   countdown       seconds left in COUNTDOWN, else 0
//   words           completed words, saturating
//   elapsed_tenths  RUNNING time in tenths of a second
//   wpm             WPM x100, saturating
//   wpm_valid       one-cycle pulse on each wpm update
module typing_session_ctrl
  import typing_pkg::*;
#(
  parameter int TICK_DIV     = 10_000_000,
  parameter int COUNTDOWN_S  = 3,
  parameter int TIME_LIMIT_S = 60,
  parameter int WORD_GOAL    = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
  input  logic              word_complete,
  input  logic              game_over_in,
  output logic              sw_reset,
  output logic              sw_start,
  output logic [1:0]        state,
  output logic [1:0]        countdown,
  output logic [WORD_W-1:0] words,
  output logic [TIME_W-1:0] elapsed_tenths,
  output logic [WPM_W-1:0]  wpm,
  output logic              wpm_valid
);

  localparam int                 PRESC_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST    = PRESC_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0]  ELAPSED_LIMIT = TIME_W'(TIME_LIMIT_S * 10);
  localparam logic [WORD_W-1:0]  WORD_LIMIT    = WORD_W'(WORD_GOAL);
  localparam logic [WORD_W-1:0]  WORD_MAX      = {WORD_W{1'b1}};
  localparam logic [1:0]         COUNT_START   = 2'(COUNTDOWN_S);

  state_t                state_r;
  logic [PRESC_W-1:0]    presc_r;
  logic [3:0]            tenth_r;
  logic [1:0]            countdown_r;
  logic [WORD_W-1:0]     words_r;
  logic [TIME_W-1:0]     elapsed_r;
  logic                  sw_reset_r;
  logic                  sw_start_r;
  logic                  div_launch_r;
  logic [DIVIDEND_W-1:0] div_dividend_r;
  logic [TIME_W-1:0]     div_divisor_r;
  logic [WPM_W-1:0]      wpm_r;
  logic                  wpm_valid_r;

  logic                  timing_s;
  logic                  tick_s;
  logic                  session_start_s;
  logic [WORD_W-1:0]     words_upd_s;
  logic [TIME_W-1:0]     elapsed_upd_s;
  logic                  finish_s;
  logic                  zero_launch_s;
  logic                  div_start_s;
  logic                  div_cancel_s;
  logic                  div_busy_s;
  logic                  div_done_s;
  logic [DIVIDEND_W-1:0] div_quotient_s;

  // Tick, post-update counter values and divider launch control.
  always_comb begin
    timing_s        = (state_r == ST_COUNTDOWN) || (state_r == ST_RUNNING);
    tick_s          = timing_s && (presc_r == PRESC_LAST);
    session_start_s = start_btn && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    if (word_complete && (words_r != WORD_MAX)) begin
      words_upd_s = words_r + WORD_W'(1);
    end else begin
      words_upd_s = words_r;
    end
    if (tick_s) begin
      elapsed_upd_s = elapsed_r + TIME_W'(1);
    end else begin
      elapsed_upd_s = elapsed_r;
    end
    // Session end is judged on the values as they will be after this edge.
    finish_s = (elapsed_upd_s == ELAPSED_LIMIT) || (words_upd_s == WORD_LIMIT) || game_over_in;
    // A zero divisor never reaches the divider; it reports wpm=0 directly.
    zero_launch_s = div_launch_r && (div_divisor_r == '0);
    div_start_s   = div_launch_r && (div_divisor_r != '0) && !session_start_s;
    div_cancel_s  = div_busy_s && (session_start_s || zero_launch_s);
  end

  // 0.1 s prescaler, free-running only while the session clock matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
    end else if (!timing_s || (presc_r == PRESC_LAST)) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  // Session FSM with counters, stopwatch controls and divide launches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      tenth_r        <= 4'd0;
      countdown_r    <= 2'd0;
      words_r        <= '0;
      elapsed_r      <= '0;
      sw_reset_r     <= 1'b1;
      sw_start_r     <= 1'b0;
      div_launch_r   <= 1'b0;
      div_dividend_r <= '0;
      div_divisor_r  <= '0;
    end else begin
      div_launch_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (session_start_s) begin
            state_r     <= ST_COUNTDOWN;
            tenth_r     <= 4'd0;
            countdown_r <= COUNT_START;
            words_r     <= '0;
            elapsed_r   <= '0;
            sw_reset_r  <= 1'b1;
            sw_start_r  <= 1'b0;
          end
        end
        ST_COUNTDOWN: begin
          if (tick_s) begin
            if (tenth_r == 4'd9) begin
              tenth_r <= 4'd0;
              // The second that would reach zero starts the game instead.
              if (countdown_r == 2'd1) begin
                state_r     <= ST_RUNNING;
                countdown_r <= 2'd0;
                sw_reset_r  <= 1'b0;
                sw_start_r  <= 1'b1;
              end else begin
                countdown_r <= countdown_r - 2'd1;
              end
            end else begin
              tenth_r <= tenth_r + 4'd1;
            end
          end
        end
        ST_RUNNING: begin
          words_r   <= words_upd_s;
          elapsed_r <= elapsed_upd_s;
          // Live divide on each tick; the final divide on exit uses the same
          // post-update operands and replaces anything still in flight.
          if (tick_s || finish_s) begin
            div_launch_r   <= 1'b1;
            div_dividend_r <= DIVIDEND_W'(words_upd_s) * DIVIDEND_W'(WPM_SCALE);
            div_divisor_r  <= elapsed_upd_s;
          end
          if (finish_s) begin
            state_r    <= ST_DONE;
            sw_start_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // WPM result register and its update strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      wpm_r       <= '0;
      wpm_valid_r <= 1'b0;
    end else if (session_start_s) begin
      wpm_r       <= '0;
      wpm_valid_r <= 1'b0;
    end else if (zero_launch_s) begin
      wpm_r       <= '0;
      wpm_valid_r <= 1'b1;
    end else if (div_done_s && !div_launch_r) begin
      // A result landing alongside a new launch belongs to an abandoned divide.
      wpm_r       <= wpm_saturate(div_quotient_s);
      wpm_valid_r <= 1'b1;
    end else begin
      wpm_valid_r <= 1'b0;
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start_s),
    .cancel   (div_cancel_s),
    .dividend (div_dividend_r),
    .divisor  (div_divisor_r),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_quotient_s)
  );

  assign state          = state_r;
  assign countdown      = countdown_r;
  assign words          = words_r;
  assign elapsed_tenths = elapsed_r;
  assign sw_reset       = sw_reset_r;
  assign sw_start       = sw_start_r;
  assign wpm            = wpm_r;
  assign wpm_valid      = wpm_valid_r;

endmodule

// File: tb/tb_typing_session_ctrl.sv
// Self-checking bench for typing_session_ctrl with a fast tick (32 clk per
// 0.1 s). The RUNNING phase is checked every cycle against an event-time
// model: ticks every TICK_DIV clocks, words counted from the pulses driven,
// and each WPM result expected at its launch cycle + 28 (or +1 for elapsed 0).
module tb_typing_session_ctrl;

  localparam int TD = 32;
  localparam int CD = 2;
  localparam int TL = 3;
  localparam int WG = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn;
  logic        word_complete;
  logic        game_over_in;
  logic        sw_reset;
  logic        sw_start;
  logic [1:0]  state;
  logic [1:0]  countdown;
  logic [10:0] words;
  logic [10:0] elapsed_tenths;
  logic [15:0] wpm;
  logic        wpm_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_wpm;
  int sched[$];
  int ev_c[$];
  int ev_v[$];

  typing_session_ctrl #(
    .TICK_DIV(TD), .COUNTDOWN_S(CD), .TIME_LIMIT_S(TL), .WORD_GOAL(WG)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .word_complete(word_complete),
    .game_over_in(game_over_in), .sw_reset(sw_reset), .sw_start(sw_start),
    .state(state), .countdown(countdown), .words(words),
    .elapsed_tenths(elapsed_tenths), .wpm(wpm), .wpm_valid(wpm_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int wpm_ref(input int w, input int e);
    int q;
    if (e == 0) return 0;
    q = (w * 60000) / e;
    return (q > 65535) ? 65535 : q;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_swr"}, sw_reset, 1);
    chk({tag, "_sws"}, sw_start, 0);
    chk({tag, "_cd"}, countdown, 0);
    chk({tag, "_words"}, words, 0);
    chk({tag, "_elapsed"}, elapsed_tenths, 0);
    chk({tag, "_wpm"}, wpm, 0);
    chk({tag, "_valid"}, wpm_valid, 0);
  endtask

  // Start a session, walk the countdown, then run until DONE plus 40 cycles.
  // Words come from 'sched' (cycle offsets into RUNNING) or randomly at pct%.
  task automatic run_session(input int pct, input int go_at);
    int  run_edge;
    int  m_w;
    int  m_e;
    int  post;
    logic wc, go, dn, tick, ev;
    last_wpm = -1;
    start_btn = 1'b1; step(); start_btn = 1'b0;
    chk("start_state", state, 1);
    chk("start_cd", countdown, CD);
    chk("start_words", words, 0);
    chk("start_elapsed", elapsed_tenths, 0);
    chk("start_wpm", wpm, 0);
    chk("start_swr", sw_reset, 1);
    chk("start_sws", sw_start, 0);
    for (int s = CD; s >= 1; s--) begin
      repeat (TD * 10 - 1) step();
      chk("cd_hold", countdown, s);
      chk("cd_state", state, 1);
      start_btn = 1'b1; step(); start_btn = 1'b0;  // must be ignored
      if (s > 1) begin
        chk("cd_dec", countdown, s - 1);
        chk("cd_state2", state, 1);
      end else begin
        chk("run_state", state, 2);
        chk("run_cd", countdown, 0);
        chk("run_sws", sw_start, 1);
        chk("run_swr", sw_reset, 0);
      end
    end
    run_edge = cyc; m_w = 0; m_e = 0; dn = 1'b0; post = 0;
    ev_c.delete(); ev_v.delete();
    for (int n = 0; n < 1100 && post < 40; n++) begin
      if (sched.size() > 0) begin
        wc = (sched[0] == n);
        if (wc) void'(sched.pop_front());
      end else begin
        wc = ($urandom_range(0, 99) < pct);
      end
      go = !dn && (n >= go_at);
      word_complete = wc;
      game_over_in  = go;
      start_btn     = !dn && ($urandom_range(0, 49) == 0);
      step();
      word_complete = 1'b0; game_over_in = 1'b0; start_btn = 1'b0;
      tick = 1'b0;
      if (!dn) begin
        if (wc && m_w < 2047) m_w++;
        if ((cyc - run_edge) % TD == 0) begin
          m_e++;
          tick = 1'b1;
        end
      end
      ev = (ev_c.size() > 0) && (ev_c[0] == cyc);
      chk("wpm_valid", wpm_valid, ev);
      if (ev) begin
        chk("wpm", wpm, ev_v[0]);
        last_wpm = int'(wpm);
        void'(ev_c.pop_front()); void'(ev_v.pop_front());
      end
      if (!dn) begin
        if (tick) begin
          ev_c.push_back(cyc + 28); ev_v.push_back(wpm_ref(m_w, m_e));
        end
        if (m_e == TL * 10 || m_w == WG || go) begin
          dn = 1'b1;
          ev_c.delete(); ev_v.delete();
          ev_c.push_back(cyc + ((m_e == 0) ? 1 : 28));
          ev_v.push_back(wpm_ref(m_w, m_e));
        end
      end else begin
        post++;
      end
      chk("state", state, dn ? 3 : 2);
      chk("words", words, m_w);
      chk("elapsed", elapsed_tenths, m_e);
      chk("sw_start", sw_start, dn ? 0 : 1);
      chk("sw_reset", sw_reset, 0);
      chk("countdown", countdown, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b0; word_complete = 1'b0; game_over_in = 1'b0;
    repeat (3) step();
    chk_reset("rst");
    reset = 1'b0;
    step();
    chk_reset("idle");

    // Word goal reached well before the time limit.
    run_session(6, 100000);
    // Three words, then the time limit: 3*60000/30 = 6000.
    sched = '{100, 200, 300};
    run_session(0, 100000);
    chk("wpm_time_limit", last_wpm, 6000);
    // Fourth word lands on the 30th tick: 4*60000/30 = 8000.
    sched = '{100, 200, 300, 959};
    run_session(0, 100000);
    chk("wpm_word_on_limit", last_wpm, 8000);
    // Game over on the first RUNNING cycle: elapsed 0, wpm 0 next cycle.
    run_session(0, 0);
    chk("wpm_game_over", last_wpm, 0);
    // Randomized sessions.
    for (int i = 0; i < 6; i++) begin
      run_session($urandom_range(0, 4),
                  ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1000) : 100000);
    end

    // Reset while a live divide is in flight.
    start_btn = 1'b1; step(); start_btn = 1'b0;
    repeat (TD * 10 * CD + TD + 5) step();
    chk("busy_state", state, 2);
    reset = 1'b1; step(); reset = 1'b0;
    chk_reset("midrst");
    for (int i = 0; i < 40; i++) begin
      step();
      chk("midrst_valid", wpm_valid, 0);
      chk("midrst_state", state, 0);
    end
    // Normal session again from IDLE.
    run_session(3, 100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
